// File: rtl/axis_uart_rx_if.sv
// AXI-Stream byte channel carrying one received UART byte plus its error flags.
interface axis_uart_rx_if;
  logic [7:0] tdata;
  logic       tvalid;
  logic       tready;
  logic [1:0] tuser;

  modport master (output tdata, output tvalid, output tuser, input tready);
  modport slave  (input tdata, input tvalid, input tuser, output tready);
endinterface

// File: rtl/axis_uart_rx.sv
// UART receiver: 16x oversampling with 3-sample majority vote, optional parity,
// stop-bit check, and a one-entry AXI-Stream output register with sticky status.
module axis_uart_rx #(
  parameter int unsigned CLK_FREQ   = 50000000,
  parameter int unsigned BAUD_RATE  = 115200,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx,
  axis_uart_rx_if.master        m_axis,
  output logic                  overrun,
  output logic                  err_sticky,
  input  logic                  err_clr,
  output logic                  busy
);

  localparam int unsigned DIV_Q = CLK_FREQ / (BAUD_RATE * 16);
  localparam int unsigned DIV   = (DIV_Q < 1) ? 1 : DIV_Q;
  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam bit          PAR_ODD = (PARITY_ODD != 0);
  localparam bit          PAR_EN  = (PARITY_EN != 0);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BRK_WAIT
  } state_t;

  state_t           state;
  logic             rx_m, rx_s;
  logic [CNT_W-1:0] div_cnt;
  logic [3:0]       tick_idx;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic             s7, s8;
  logic             par_err;

  logic tick_c, maj_c, decide_c, adv_c;

  // Two-flop synchronizer; line idles high so reset to 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  always_comb begin
    tick_c   = (div_cnt == CNT_W'(DIV - 1));
    maj_c    = (s7 & s8) | (s7 & rx_s) | (s8 & rx_s);
    decide_c = tick_c && (tick_idx == 4'd9);
    adv_c    = tick_c && (tick_idx == 4'd15);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      div_cnt       <= '0;
      tick_idx      <= '0;
      bit_idx       <= '0;
      shreg         <= '0;
      s7            <= 1'b0;
      s8            <= 1'b0;
      par_err       <= 1'b0;
      busy          <= 1'b0;
      m_axis.tdata  <= '0;
      m_axis.tvalid <= 1'b0;
      m_axis.tuser  <= '0;
      overrun       <= 1'b0;
      err_sticky    <= 1'b0;
    end else begin
      // Free-running divider, re-phased on the start edge.
      if ((state == S_IDLE && !rx_s) || tick_c) div_cnt <= '0;
      else                                      div_cnt <= div_cnt + CNT_W'(1);

      if (tick_c) begin
        tick_idx <= tick_idx + 4'd1;
        if (tick_idx == 4'd7) s7 <= rx_s;
        if (tick_idx == 4'd8) s8 <= rx_s;
      end

      if (m_axis.tvalid && m_axis.tready) m_axis.tvalid <= 1'b0;

      case (state)
        S_IDLE: begin
          if (!rx_s) begin
            state    <= S_START;
            tick_idx <= '0;
            par_err  <= 1'b0;
            busy     <= 1'b1;
          end
        end
        S_START: begin
          if (decide_c && maj_c) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else if (adv_c) begin
            state   <= S_DATA;
            bit_idx <= '0;
          end
        end
        S_DATA: begin
          if (decide_c) shreg <= {maj_c, shreg[7:1]};
          if (adv_c) begin
            if (bit_idx == 3'd7) state <= PAR_EN ? S_PARITY : S_STOP;
            else                 bit_idx <= bit_idx + 3'd1;
          end
        end
        S_PARITY: begin
          if (decide_c) par_err <= (((^shreg) ^ maj_c) != PAR_ODD);
          if (adv_c)    state   <= S_STOP;
        end
        S_STOP: begin
          // Deliver at the stop decision; leave early so the next start edge is caught.
          if (decide_c) begin
            if (!m_axis.tvalid || m_axis.tready) begin
              m_axis.tdata  <= shreg;
              m_axis.tuser  <= {par_err, ~maj_c};
              m_axis.tvalid <= 1'b1;
            end else begin
              overrun <= 1'b1;
            end
            if (par_err || !maj_c) err_sticky <= 1'b1;
            if (maj_c) begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end else begin
              state <= S_BRK_WAIT;
            end
          end
        end
        S_BRK_WAIT: begin
          if (rx_s) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase

      // Clear beats any same-cycle set.
      if (err_clr) begin
        overrun    <= 1'b0;
        err_sticky <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axis_uart_rx.sv
// Directed bench for axis_uart_rx: 8N1 instance plus an even-parity instance,
// DIV=10 so one bit is 160 clocks.
module tb_axis_uart_rx;
  localparam int unsigned CLK_FREQ = 1600000;
  localparam int unsigned BAUD     = 10000;
  localparam int          BIT      = 160;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx1 = 1'b1, rx2 = 1'b1;
  logic clr1 = 1'b0, clr2 = 1'b0;
  logic ovr1, ovr2, sticky1, sticky2, busy1, busy2;

  axis_uart_rx_if ax1 ();
  axis_uart_rx_if ax2 ();

  axis_uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .PARITY_EN(0), .PARITY_ODD(0)) dut1 (
    .clk(clk), .rst(rst), .rx(rx1), .m_axis(ax1), .overrun(ovr1),
    .err_sticky(sticky1), .err_clr(clr1), .busy(busy1));

  axis_uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .PARITY_EN(1), .PARITY_ODD(0)) dut2 (
    .clk(clk), .rst(rst), .rx(rx2), .m_axis(ax2), .overrun(ovr2),
    .err_sticky(sticky2), .err_clr(clr2), .busy(busy2));

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  logic [9:0] q1[$];
  logic [9:0] q2[$];

  // Beat capture: tready only changes just after posedge, so negedge sees the coming handshake.
  always @(negedge clk) begin
    if (!rst) begin
      if (ax1.tvalid && ax1.tready) q1.push_back({ax1.tuser, ax1.tdata});
      if (ax2.tvalid && ax2.tready) q2.push_back({ax2.tuser, ax2.tdata});
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input int sel, input logic b);
    @(posedge clk);
    #1;
    if (sel == 2) rx2 = b;
    else          rx1 = b;
    repeat (BIT - 1) @(posedge clk);
  endtask

  task automatic send_frame(input int sel, input logic [7:0] d, input logic stop,
                            input logic par_en, input logic par);
    send_bit(sel, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(sel, d[i]);
    if (par_en) send_bit(sel, par);
    send_bit(sel, stop);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    idle(4);
    vectors++; if (ax1.tvalid !== 1'b0) begin miscompares++; $display("FAIL reset_tvalid: got %b expected 0", ax1.tvalid); end
    vectors++; if (ax1.tdata !== 8'h00) begin miscompares++; $display("FAIL reset_tdata: got %h expected 00", ax1.tdata); end
    vectors++; if (ax1.tuser !== 2'b00) begin miscompares++; $display("FAIL reset_tuser: got %b expected 00", ax1.tuser); end
    vectors++; if ({ovr1, sticky1, busy1} !== 3'b000) begin miscompares++; $display("FAIL reset_status: got %b expected 000", {ovr1, sticky1, busy1}); end
    vectors++; if ({ax2.tvalid, ovr2, sticky2, busy2} !== 4'b0000) begin miscompares++; $display("FAIL reset_dut2: got %b expected 0000", {ax2.tvalid, ovr2, sticky2, busy2}); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(20);
  endtask

  task automatic test_single_byte;
    logic [9:0] fr;
    int first;
    fr = {1'b1, 8'h55, 1'b0};
    first = -1;
    q1.delete();
    ax1.tready = 1'b1;
    // Start drive after P0; START entry at P3; stop tick 9 at P3+10*(16*9+10) -> tvalid after P1543.
    for (int c = 0; c < 10 * BIT; c++) begin
      @(posedge clk);
      #1;
      rx1 = fr[c / BIT];
      @(negedge clk);
      if (ax1.tvalid && first < 0) first = c;
    end
    idle(20);
    vectors++; if (first !== 1543) begin miscompares++; $display("FAIL latency: got %0d expected 1543", first); end
    vectors++; if (q1.size() !== 1) begin miscompares++; $display("FAIL single_count: got %0d expected 1", q1.size()); end
    vectors++; if (q1[0] !== {2'b00, 8'h55}) begin miscompares++; $display("FAIL single_beat: got %h expected 055", q1[0]); end
    vectors++; if ({ax1.tvalid, ovr1, busy1} !== 3'b000) begin miscompares++; $display("FAIL single_after: got %b expected 000", {ax1.tvalid, ovr1, busy1}); end
  endtask

  task automatic test_back_to_back;
    q1.delete();
    send_frame(1, 8'hA5, 1'b1, 1'b0, 1'b0);
    send_frame(1, 8'h3C, 1'b1, 1'b0, 1'b0);
    idle(200);
    vectors++; if (q1.size() !== 2) begin miscompares++; $display("FAIL b2b_count: got %0d expected 2", q1.size()); end
    vectors++; if (q1[0] !== {2'b00, 8'hA5}) begin miscompares++; $display("FAIL b2b_first: got %h expected 0a5", q1[0]); end
    vectors++; if (q1[1] !== {2'b00, 8'h3C}) begin miscompares++; $display("FAIL b2b_second: got %h expected 03c", q1[1]); end
  endtask

  task automatic test_overrun;
    q1.delete();
    ax1.tready = 1'b0;
    send_frame(1, 8'h11, 1'b1, 1'b0, 1'b0);
    send_frame(1, 8'h22, 1'b1, 1'b0, 1'b0);
    idle(100);
    vectors++; if ({ax1.tvalid, ax1.tdata} !== {1'b1, 8'h11}) begin miscompares++; $display("FAIL ovr_hold: got %b/%h expected 1/11", ax1.tvalid, ax1.tdata); end
    vectors++; if (ovr1 !== 1'b1) begin miscompares++; $display("FAIL ovr_flag: got %b expected 1", ovr1); end
    vectors++; if (sticky1 !== 1'b0) begin miscompares++; $display("FAIL ovr_sticky: got %b expected 0", sticky1); end
    ax1.tready = 1'b1;
    idle(10);
    vectors++; if (q1.size() !== 1 || q1[0] !== {2'b00, 8'h11}) begin miscompares++; $display("FAIL ovr_drain: got n=%0d %h expected n=1 011", q1.size(), q1[0]); end
    vectors++; if (ax1.tvalid !== 1'b0) begin miscompares++; $display("FAIL ovr_tvalid_drop: got %b expected 0", ax1.tvalid); end
    clr1 = 1'b1;
    idle(1);
    clr1 = 1'b0;
    idle(2);
    vectors++; if (ovr1 !== 1'b0) begin miscompares++; $display("FAIL ovr_clear: got %b expected 0", ovr1); end
  endtask

  task automatic test_framing;
    q1.delete();
    ax1.tready = 1'b1;
    send_frame(1, 8'hF0, 1'b0, 1'b0, 1'b0);
    repeat (3 * BIT) @(posedge clk);
    #1;
    vectors++; if (q1.size() !== 1 || q1[0] !== {2'b01, 8'hF0}) begin miscompares++; $display("FAIL frm_beat: got n=%0d %h expected n=1 1f0", q1.size(), q1[0]); end
    vectors++; if (sticky1 !== 1'b1) begin miscompares++; $display("FAIL frm_sticky: got %b expected 1", sticky1); end
    vectors++; if (busy1 !== 1'b1) begin miscompares++; $display("FAIL frm_busy_low: got %b expected 1", busy1); end
    rx1 = 1'b1;
    idle(10);
    vectors++; if (busy1 !== 1'b0) begin miscompares++; $display("FAIL frm_busy_release: got %b expected 0", busy1); end
    vectors++; if (q1.size() !== 1) begin miscompares++; $display("FAIL frm_no_extra: got %0d expected 1", q1.size()); end
    clr1 = 1'b1;
    idle(1);
    clr1 = 1'b0;
    idle(2);
    vectors++; if (sticky1 !== 1'b0) begin miscompares++; $display("FAIL frm_clear: got %b expected 0", sticky1); end
  endtask

  task automatic test_glitch;
    q1.delete();
    rx1 = 1'b0;
    idle(20);
    vectors++; if (busy1 !== 1'b1) begin miscompares++; $display("FAIL glitch_busy: got %b expected 1", busy1); end
    idle(10);
    rx1 = 1'b1;
    idle(300);
    vectors++; if (busy1 !== 1'b0 || q1.size() !== 0) begin miscompares++; $display("FAIL glitch_reject: got busy=%b n=%0d expected busy=0 n=0", busy1, q1.size()); end
    send_frame(1, 8'h7E, 1'b1, 1'b0, 1'b0);
    idle(100);
    vectors++; if (q1.size() !== 1 || q1[0] !== {2'b00, 8'h7E}) begin miscompares++; $display("FAIL glitch_next: got n=%0d %h expected n=1 07e", q1.size(), q1[0]); end
  endtask

  task automatic test_parity;
    q2.delete();
    ax2.tready = 1'b1;
    send_frame(2, 8'h03, 1'b1, 1'b1, 1'b1);
    idle(100);
    vectors++; if (q2.size() !== 1 || q2[0] !== {2'b10, 8'h03}) begin miscompares++; $display("FAIL par_bad: got n=%0d %h expected n=1 203", q2.size(), q2[0]); end
    vectors++; if (sticky2 !== 1'b1) begin miscompares++; $display("FAIL par_sticky: got %b expected 1", sticky2); end
    send_frame(2, 8'h03, 1'b1, 1'b1, 1'b0);
    idle(100);
    vectors++; if (q2.size() !== 2 || q2[1] !== {2'b00, 8'h03}) begin miscompares++; $display("FAIL par_good: got n=%0d %h expected n=2 003", q2.size(), q2[1]); end
  endtask

  task automatic test_reset_mid;
    q1.delete();
    ax1.tready = 1'b0;
    send_frame(1, 8'h5A, 1'b1, 1'b0, 1'b0);
    idle(50);
    vectors++; if (ax1.tvalid !== 1'b1) begin miscompares++; $display("FAIL rmid_held: got %b expected 1", ax1.tvalid); end
    send_bit(1, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(1, i[0]);
    #1;
    vectors++; if (busy1 !== 1'b1) begin miscompares++; $display("FAIL rmid_busy_pre: got %b expected 1", busy1); end
    rst = 1'b1;
    rx1 = 1'b1;
    #1;
    vectors++; if ({ax1.tvalid, busy1} !== 2'b00) begin miscompares++; $display("FAIL rmid_async: got %b expected 00", {ax1.tvalid, busy1}); end
    idle(3);
    rst = 1'b0;
    ax1.tready = 1'b1;
    idle(50);
    send_frame(1, 8'hC3, 1'b1, 1'b0, 1'b0);
    idle(100);
    vectors++; if (q1.size() !== 1 || q1[0] !== {2'b00, 8'hC3}) begin miscompares++; $display("FAIL rmid_next: got n=%0d %h expected n=1 0c3", q1.size(), q1[0]); end
  endtask

  initial begin
    ax1.tready = 1'b1;
    ax2.tready = 1'b1;
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_overrun();
    test_framing();
    test_glitch();
    test_parity();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/axis_uart_rx.md
Name: axis_uart_rx

Overview:
- UART receive front end that feeds the AXI-Stream side of the design. It is the mirror of the TX path, and the `uart_tx` line can be looped back into it.
- It oversamples the serial `rx` line 16x and majority-votes each bit.
- It checks optional parity and the stop bit.
- It presents each received byte on an AXI-Stream master port with a one-entry output register.
- Error and overrun status are reported per byte and as sticky flags.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- BAUD_RATE, 115200, serial bit rate.
- PARITY_EN, 0, 1 = a parity bit follows the 8 data bits.
- PARITY_ODD, 0, 1 = odd parity, 0 = even parity (used only when PARITY_EN=1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- rx  in  1  serial input; idles high; asynchronous to clk.
- m_axis_tdata  out  8  received byte.
- m_axis_tvalid  out  1  byte available.
- m_axis_tready  in  1  downstream accepts.
- m_axis_tuser  out  2  [0] = framing error, [1] = parity error, both for this byte.
- overrun  out  1  sticky: a byte was dropped because the output register was full.
- err_sticky  out  1  sticky: OR of every framing or parity error since the last clear.
- err_clr  in  1  single-cycle pulse; clears overrun and err_sticky.
- busy  out  1  high while the FSM is outside IDLE.

Behaviour:
- Reset is asynchronous, active-high, and affects all state:
  - all outputs go to 0;
  - synchronizer flops go to 1;
  - FSM goes to IDLE and the tick counter to 0.
  - Reset mid-frame abandons the frame; no byte is emitted.
- Synchronizer: two flops on `rx`; all logic uses the second flop (rx_s).
- Tick generator:
  - DIV = CLK_FREQ/(BAUD_RATE*16), integer truncation, minimum 1.
  - A one-clk `tick` pulse fires every DIV clks; the counter wraps from DIV-1 to 0.
  - The counter free-runs, and is reset to 0 on entry to START so the sample phase aligns to the start edge.
- Bit timing: each bit spans 16 ticks, indexed 0..15.
  - The bit value is the majority of rx_s sampled on ticks 7, 8 and 9.
  - The bit is decided at tick 9 and the state advances at tick 15.
- FSM:
  - IDLE: rx_s==0 -> START (tick counter cleared).
  - START: at the tick-9 decision, majority==1 -> IDLE (glitch, nothing emitted); otherwise continue, and at tick 15 -> DATA with bit index 0.
  - DATA: shift bits in LSB first. After bit 7 -> PARITY if PARITY_EN, else STOP.
  - PARITY:
    - parity_err = (XOR(data) ^ received bit) != PARITY_ODD; that is, even parity requires the data XOR to equal the parity bit, odd requires it to differ.
    - -> STOP.
  - STOP:
    - At the tick-9 decision: frame_err = (majority==0), then deliver the byte.
    - If frame_err==0 -> IDLE immediately, without waiting for tick 15, so the next start edge is not missed.
    - If frame_err==1 -> BRK_WAIT.
  - BRK_WAIT: stay until rx_s==1, then -> IDLE. This covers break and line-held-low cases.
- Delivery, in the clk after the stop decision:
  - If the output register is empty, or is being accepted this same clk (tvalid & tready): load tdata and tuser, set tvalid=1.
  - Otherwise the new byte is discarded, overrun<=1, and the held register is unchanged.
  - A byte with an error is still delivered, with its tuser bits set.
  - err_sticky is set on delivery of any byte with nonzero tuser, including a dropped byte.
- AXIS rules:
  - While tvalid=1 and tready=0, tdata and tuser stay stable.
  - tvalid falls the clk after the handshake unless a new byte loads in that same clk.
  - tvalid does not depend combinationally on tready.
- Simultaneous events:
  - err_clr takes priority over a same-cycle set; the set event is lost and this is documented behaviour.
  - Handshake and load in the same clk: the load wins and tvalid stays 1.
- Latency: tvalid rises 1 clk after the tick-9 clk of the stop bit.
- busy: high from the start-edge detect until IDLE is re-entered.

Test Plan:
- Byte 0x55, 8N1, tready=1 -> one beat: tdata=0x55, tuser=0, overrun=0; tvalid rises 1 clk after the stop tick 9.
  - Bench overrides: CLK_FREQ=1600000, BAUD_RATE=10000, giving DIV=10 and 160 clk/bit.
- Back-to-back 0xA5 then 0x3C with no idle gap, tready=1 -> beats 0xA5 then 0x3C in order, tuser=0 on both.
- tready=0 while 0x11 then 0x22 arrive -> register holds 0x11 and overrun=1. After tready=1, one beat 0x11; 0x22 is lost. Pulse err_clr -> overrun=0.
- Stop bit driven low on byte 0xF0 -> beat with tdata=0xF0, tuser=01 and err_sticky=1. Hold rx low for 3 bit times -> no further beats, busy=1 until rx returns high.
- Start-bit glitch (rx low for 3 ticks only) -> FSM returns to IDLE, no beat. A following valid 0x7E is received correctly.
- PARITY_EN=1, PARITY_ODD=0, byte 0x03 with parity bit 1 -> tuser=10.
- Reset asserted mid-DATA -> tvalid=0, busy=0 immediately; the next frame 0xC3 is received cleanly.
